// File: rtl/cpu_boot_dump_ctrl_pkg.sv
// Shared types for the boot/run/dump sequencer: state encoding and small helpers.
// The host-side model uses the same 3-bit state values when it decodes dbg_state.
package cpu_boot_dump_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RUN      = 3'd2,
    ST_DUMP_RD  = 3'd3,
    ST_DUMP_OUT = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  function automatic logic state_is_busy(input state_e s);
    return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_DUMP_RD) || (s == ST_DUMP_OUT);
  endfunction

endpackage

// File: rtl/cpu_boot_dump_ctrl_cycle_counter.sv
// Run-cycle budget counter: counts enabled cycles from 0 and flags the last budgeted cycle.
// A limit of 0 means the budget never expires.
module boot_cycle_counter #(
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CYC_W-1:0] limit,
  output logic             expire
);

  logic [CYC_W-1:0] count_q;
  logic [CYC_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = en && (limit != '0) && (count_q == (limit - CYC_W'(1)));

endmodule

// File: rtl/cpu_boot_dump_ctrl.sv
// Boot/run/dump sequencer between a host stream and the CPU RAM port.
// Valid/ready: a word moves on any cycle where valid and ready are both high at the clock edge.
module cpu_boot_dump_ctrl
  import cpu_boot_dump_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int CYC_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CYC_W-1:0]    run_cycles,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  output logic                mem_we,
  output logic                mem_re,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                cpu_rst_n,
  input  logic                cpu_halt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [STATE_W-1:0]  dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CYC_W-1:0]    budget_q, budget_d;
  logic                timeout_q, timeout_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                hold_q, hold_d;
  logic                cnt_expire;

  boot_cycle_counter #(
    .CYC_W (CYC_W)
  ) u_cycle_counter (
    .clk    (clk),
    .rst_n  (rst),
    .clr    (state_q != ST_RUN),
    .en     (state_q == ST_RUN),
    .limit  (budget_q),
    .expire (cnt_expire)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    budget_d  = budget_q;
    timeout_d = timeout_q;
    data_d    = data_q;
    hold_d    = hold_q;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    out_valid = 1'b0;
    out_data  = data_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_LOAD;
          addr_d    = '0;
          budget_d  = run_cycles;
          timeout_d = 1'b0;
        end
      end

      ST_LOAD: begin
        in_ready  = 1'b1;
        mem_we    = in_valid;
        mem_wdata = in_data;
        if (in_valid) begin
          if (in_last || (addr_q == LAST_ADDR)) begin
            state_d = ST_RUN;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      ST_RUN: begin
        // Halt is tested first so a halt on the expiry cycle is not reported as a timeout.
        if (cpu_halt) begin
          state_d = ST_DUMP_RD;
          addr_d  = '0;
        end else if (cnt_expire) begin
          state_d   = ST_DUMP_RD;
          addr_d    = '0;
          timeout_d = 1'b1;
        end
      end

      ST_DUMP_RD: begin
        mem_re  = 1'b1;
        hold_d  = 1'b0;
        state_d = ST_DUMP_OUT;
      end

      ST_DUMP_OUT: begin
        out_valid = 1'b1;
        // First DUMP_OUT cycle forwards the fresh read data and captures it for any stall.
        if (!hold_q) begin
          out_data = mem_rdata;
          data_d   = mem_rdata;
          hold_d   = 1'b1;
        end
        if (out_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_DUMP_RD;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cpu_rst_n_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      budget_q    <= '0;
      timeout_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      data_q      <= '0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      budget_q    <= budget_d;
      timeout_q   <= timeout_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      data_q      <= data_d;
      hold_q      <= hold_d;
    end
  end

  assign mem_addr  = addr_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign out_last  = (state_q == ST_DUMP_OUT) && (addr_q == LAST_ADDR);
  assign busy      = state_is_busy(state_q);
  assign done      = (state_q == ST_DONE);
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_boot_dump_ctrl.sv
// Directed/random bench for cpu_boot_dump_ctrl: RAM model, rule-level expected RAM image,
// randomized valid/ready timing, immediate assertions at every comparison.
module tb_cpu_boot_dump_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 16;
  localparam int CYC_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CYC_W-1:0]  run_cycles;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_rst_n;
  logic              cpu_halt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [2:0]        dbg_state;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] ram     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] exp_ram [0:DEPTH-1];
  logic [DATA_W-1:0] exp_q[$];

  cpu_boot_dump_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CYC_W  (CYC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .run_cycles (run_cycles),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .cpu_rst_n  (cpu_rst_n),
    .cpu_halt   (cpu_halt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / environment ----------------
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] fill_pat(input int i);
    return 32'hC0DE_0000 ^ 32'(i * 37);
  endfunction

  // Single-port RAM, one-cycle read latency; refilled with a known pattern while reset is low.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= fill_pat(i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 64'({in_ready, mem_we, mem_re, cpu_rst_n, out_valid, out_last,
                            busy, done, timeout}), 64'(0));
    chk({tag, "_addr"},  64'(mem_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_odata"}, 64'(out_data), 64'(0));
    chk({tag, "_state"}, 64'(dbg_state), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0; cpu_halt = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) exp_ram[i] = fill_pat(i);
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_op(input int budget);
    run_cycles = CYC_W'(budget);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_flags", 64'({busy, done, timeout, cpu_rst_n, in_ready}), 64'(5'b10001));
  endtask

  task automatic load(input int n, input int last_at, input bit stray, input bit fixed);
    logic [DATA_W-1:0] word [0:DEPTH+1];
    int  idx = 0;
    int  n_acc;
    bit  fin = 1'b0;
    logic was_ready;
    logic acc;
    for (int i = 0; i < n; i++) word[i] = fixed ? DATA_W'((i + 1) * 17) : $urandom();
    n_acc = (last_at >= 0) ? last_at + 1 : n;
    if (n_acc > DEPTH) n_acc = DEPTH;
    for (int c = 0; c < 400; c++) begin
      in_valid = (idx < n) && ($urandom_range(0, 3) != 0);
      in_data  = (idx < n) ? word[idx] : $urandom();
      in_last  = in_valid && (idx == last_at);
      if (stray) begin
        start = 1'($urandom_range(0, 1));
        run_cycles = CYC_W'($urandom_range(1, 5));
      end
      #1;
      was_ready = in_ready;
      acc = in_valid && was_ready;
      if (!was_ready) begin
        fin = 1'b1;
        break;
      end
      if (acc) chk("load_wr", 64'({mem_we, mem_addr, mem_wdata}),
                   64'({1'b1, ADDR_W'(idx), word[idx]}));
      else     chk("load_idle_we", 64'(mem_we), 64'(0));
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    chk("load_bound", 64'(fin), 64'(1));
    chk("no_wr_after_load", 64'(mem_we), 64'(0));
    chk("load_count", 64'(idx), 64'(n_acc));
    chk("run_entry", 64'({in_ready, cpu_rst_n, busy}), 64'(3'b011));
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    for (int i = 0; i < n_acc; i++) exp_ram[i] = word[i];
  endtask

  task automatic run(input int budget, input int halt_at, input bit stray);
    int hi = 0;
    int exp_hi;
    bit fin = 1'b0;
    bit exp_to;
    for (int c = 0; c < 300; c++) begin
      if (cpu_rst_n) hi++;
      else if (hi > 0) begin
        fin = 1'b1;
        break;
      end
      cpu_halt = (halt_at != 0) && (hi >= halt_at);
      if (stray) begin
        start = 1'($urandom_range(0, 1));
        run_cycles = CYC_W'($urandom_range(1, 3));
      end
      step();
    end
    cpu_halt = 1'b0;
    start    = 1'b0;
    if (budget == 0)       exp_hi = halt_at;
    else if (halt_at == 0) exp_hi = budget;
    else                   exp_hi = (budget < halt_at) ? budget : halt_at;
    exp_to = (budget != 0) && ((halt_at == 0) || (budget < halt_at));
    chk("run_bound", 64'(fin), 64'(1));
    chk("run_len", 64'(hi), 64'(exp_hi));
    chk("run_timeout", 64'(timeout), 64'(exp_to));
    chk("dump_rd", 64'({busy, mem_re, mem_addr}), 64'({1'b1, 1'b1, ADDR_W'(0)}));
  endtask

  task automatic dump(input bit stray);
    bit stalled = 1'b0;
    bit fin = 1'b0;
    bit is_last;
    logic [DATA_W-1:0] prev_data = '0;
    logic              prev_last = 1'b0;
    logic [DATA_W-1:0] e;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(exp_ram[i]);
    for (int c = 0; c < 400; c++) begin
      start = 1'b0;
      if (done) begin
        fin = 1'b1;
        break;
      end
      if (stalled) chk("dump_stable", 64'({out_valid, out_last, out_data}),
                       64'({1'b1, prev_last, prev_data}));
      out_ready = 1'($urandom_range(0, 1));
      if (stray) begin
        start = 1'($urandom_range(0, 1));
        run_cycles = CYC_W'($urandom_range(1, 3));
      end
      #1;
      if (out_valid) begin
        if (out_ready) begin
          is_last = (exp_q.size() == 1);
          if (exp_q.size() == 0) chk("dump_extra", 64'(1), 64'(0));
          else begin
            e = exp_q.pop_front();
            chk("dump_data", 64'(out_data), 64'(e));
            chk("dump_last", 64'(out_last), 64'(is_last));
          end
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          prev_data = out_data;
          prev_last = out_last;
        end
      end else begin
        chk("last_without_valid", 64'(out_last), 64'(0));
        stalled = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    start     = 1'b0;
    chk("dump_bound", 64'(fin), 64'(1));
    chk("dump_missing", 64'(exp_q.size()), 64'(0));
    chk("done_state", 64'({done, busy, cpu_rst_n, out_valid, in_ready}), 64'(5'b10000));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0; start = 1'b0; run_cycles = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cpu_halt = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    check_zero("reset");
    rst = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) exp_ram[i] = fill_pat(i);

    // Reset in the middle of a load aborts straight back to IDLE.
    start_op(10);
    in_valid = 1'b1; in_data = 32'hDEAD_0001;
    step();
    in_data = 32'hDEAD_0002;
    step();
    rst = 1'b0;
    #1;
    check_zero("mid_load_rst");
    do_reset();

    // Fixed 4-word image, halt in the 5th RUN cycle.
    start_op(10);
    load(4, 3, 1'b0, 1'b1);
    run(10, 5, 1'b0);
    dump(1'b0);

    // Budget expiry, then halt coinciding with expiry.
    start_op(3);
    load(5, 4, 1'b0, 1'b0);
    run(3, 0, 1'b0);
    dump(1'b0);
    start_op(3);
    load(3, 2, 1'b0, 1'b0);
    run(3, 3, 1'b0);
    dump(1'b0);

    // Overlong load without in_last, unlimited budget.
    start_op(0);
    load(DEPTH + 2, -1, 1'b0, 1'b0);
    run(0, 7, 1'b0);
    dump(1'b0);

    // Restart from DONE with stray start pulses in every busy phase.
    start_op(20);
    load(6, 5, 1'b1, 1'b0);
    run(20, 4, 1'b1);
    dump(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
